// File: rtl/dsp_seq_ctrl.sv
// rtl/dsp_seq_ctrl.sv - sample sequencing controller in front of dsp_unit
module dsp_seq_ctrl #(
  parameter int                 DATA_W       = 32,
  parameter int                 CTRL_W       = 5,
  parameter int                 FIFO_DEPTH   = 4,
  parameter int                 DSP_LATENCY  = 2,
  parameter int                 FLUSH_CYCLES = 2,
  parameter logic [CTRL_W-1:0]  RESET_MODE   = 5'b00001
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_sample,
  input  logic                          cfg_we,
  input  logic [CTRL_W-1:0]             cfg_mode,
  output logic                          cfg_pending,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_sample,
  output logic [CTRL_W-1:0]             dsp_control,
  output logic [DATA_W-1:0]             dsp_sample,
  output logic                          dsp_rst,
  input  logic [DATA_W-1:0]             dsp_result,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(DSP_LATENCY + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(DSP_LATENCY);
  localparam logic [FCNT_W-1:0] FLSH_LOAD = FCNT_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [FCNT_W-1:0]   r_flush_cnt;
  logic [CTRL_W-1:0]   r_pend_mode;
  logic                r_cfg_pending;
  logic [CTRL_W-1:0]   r_dsp_control;
  logic [DATA_W-1:0]   r_dsp_sample;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_sample;

  logic                w_in_ready;
  logic                w_push;
  logic                w_fifo_empty;
  logic                w_out_free;
  logic                w_pop;
  logic                w_apply_mode;
  logic                w_capture;
  logic                w_dsp_rst;

  // Full check uses the registered count only, so a full FIFO refuses a push even on a pop cycle
  always_comb begin
    w_in_ready   = (r_count != FULL_CNT);
    w_push       = in_valid && w_in_ready;
    w_fifo_empty = (r_count == '0);
    w_out_free   = !r_out_valid || out_ready;
  end

  // State register; reset parks the datapath in a flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FLUSH;
    else          r_state <= w_next_state;
  end

  // Next-state: pending mode beats a waiting sample so modes only change between samples
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FLUSH: if (r_flush_cnt == FCNT_W'(1)) w_next_state = S_IDLE;
      S_IDLE: begin
        if (r_cfg_pending)                   w_next_state = S_FLUSH;
        else if (!w_fifo_empty && w_out_free) w_next_state = S_WAIT;
      end
      S_WAIT:  if (r_wait_cnt == WCNT_W'(1)) w_next_state = S_IDLE;
      default: w_next_state = S_FLUSH;
    endcase
  end

  // Output decode: per-state strobes that drive the datapath registers
  always_comb begin
    w_pop        = 1'b0;
    w_apply_mode = 1'b0;
    w_capture    = 1'b0;
    w_dsp_rst    = 1'b0;
    case (r_state)
      S_FLUSH: w_dsp_rst = 1'b1;
      S_IDLE: begin
        w_apply_mode = r_cfg_pending;
        w_pop        = !r_cfg_pending && !w_fifo_empty && w_out_free;
      end
      S_WAIT:  w_capture = (r_wait_cnt == WCNT_W'(1));
      default: w_dsp_rst = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_sample;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush and latency counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= FLSH_LOAD;
      r_wait_cnt  <= '0;
    end else begin
      if (w_apply_mode)
        r_flush_cnt <= FLSH_LOAD;
      else if (r_state == S_FLUSH && r_flush_cnt != '0)
        r_flush_cnt <= r_flush_cnt - FCNT_W'(1);
      if (w_pop)
        r_wait_cnt <= WAIT_LOAD;
      else if (r_state == S_WAIT && r_wait_cnt != '0)
        r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
    end
  end

  // Mode staging: last write wins, and a write on the apply edge stays pending for the next flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_mode   <= RESET_MODE;
      r_cfg_pending <= 1'b0;
      r_dsp_control <= RESET_MODE;
    end else begin
      if (w_apply_mode) r_dsp_control <= r_pend_mode;
      if (cfg_we) begin
        r_pend_mode   <= cfg_mode;
        r_cfg_pending <= 1'b1;
      end else if (w_apply_mode) begin
        r_cfg_pending <= 1'b0;
      end
    end
  end

  // Sample register feeding the datapath: zeroed for a flush, held stable through WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_dsp_sample <= '0;
    else if (w_apply_mode) r_dsp_sample <= '0;
    else if (w_pop)        r_dsp_sample <= r_mem[r_rd_ptr];
  end

  // Output register: a capture wins over a same-cycle acceptance of the previous result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_sample <= dsp_result;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign cfg_pending = r_cfg_pending;
  assign out_valid   = r_out_valid;
  assign out_sample  = r_out_sample;
  assign dsp_control = r_dsp_control;
  assign dsp_sample  = r_dsp_sample;
  assign dsp_rst     = w_dsp_rst;
  assign fifo_count  = r_count;

endmodule
